// File: rtl/booth_pkg.sv
// Shared types, recoding digits and step-count helper for the sequential Booth multiplier.
// Build option BOOTH_RADIX4_EN selects radix-4 recoding; otherwise radix-2.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {ZERO, PM, NM, P2M, N2M} digit_t;

`ifdef BOOTH_RADIX4_EN
    localparam int GRP_W  = 3;
    localparam int SHIFT  = 2;
    localparam int HI_EXT = 2;
`else
    localparam int GRP_W  = 2;
    localparam int SHIFT  = 1;
    localparam int HI_EXT = 1;
`endif

    function automatic int num_steps(input int width);
        return width / SHIFT;
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Booth recoder: maps the examined multiplier bit group {LO, q-1} to a digit select.
// Group width follows BOOTH_RADIX4_EN through booth_pkg.
module booth_recode
    import booth_pkg::*;
(
    input  logic [GRP_W-1:0] grp,
    output digit_t           digit
);

    always_comb begin
        digit = ZERO;
`ifdef BOOTH_RADIX4_EN
        case (grp)
            3'b001, 3'b010: digit = PM;
            3'b011:         digit = P2M;
            3'b100:         digit = N2M;
            3'b101, 3'b110: digit = NM;
            default:        digit = ZERO;
        endcase
`else
        case (grp)
            2'b01:   digit = PM;
            2'b10:   digit = NM;
            default: digit = ZERO;
        endcase
`endif
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Multi-cycle signed Booth multiplier with start/busy/done handshake.
// Define BOOTH_RADIX4_EN for radix-4 recoding (WIDTH/2 steps); default is radix-2 (WIDTH steps).
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   PRODUCT
);

    localparam int N_STEPS = num_steps(WIDTH);
    localparam int HW      = WIDTH + HI_EXT;
    localparam int ACC_W   = HW + WIDTH + 1;
    localparam int CNT_W   = $clog2(N_STEPS + 1);

`ifdef BOOTH_RADIX4_EN
    if (WIDTH % 2 != 0) begin : g_odd_width
        $error("booth_multiplier_seq: WIDTH must be even for radix-4 recoding");
    end
`endif

    state_t                  state;
    logic signed [HW-1:0]    m;
    logic signed [HW-1:0]    hi;
    logic signed [HW-1:0]    hi_sum;
    logic [WIDTH-1:0]        lo;
    logic                    q;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_sh;
    digit_t                  digit;
    logic                    load;

    booth_recode u_recode (
        .grp   ({lo[GRP_W-2:0], q}),
        .digit (digit)
    );

    // Extra HI headroom keeps -M and -2M from overflowing for full-range operands.
    always_comb begin
        hi_sum = hi;
        case (digit)
            PM:      hi_sum = hi + m;
            NM:      hi_sum = hi - m;
            P2M:     hi_sum = hi + (m <<< 1);
            N2M:     hi_sum = hi - (m <<< 1);
            default: hi_sum = hi;
        endcase
        acc_sum = {hi_sum, lo, q};
        acc_sh  = acc_sum >>> SHIFT;
    end

    // Operands are only captured when the unit is free: from IDLE or on the DONE cycle.
    assign load = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            PRODUCT <= '0;
            m       <= '0;
            hi      <= '0;
            lo      <= '0;
            q       <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                RUN: begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    hi   <= acc_sh[ACC_W-1 -: HW];
                    lo   <= acc_sh[WIDTH:1];
                    q    <= acc_sh[0];
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    PRODUCT <= {hi[WIDTH-1:0], lo};
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                m     <= {{HI_EXT{A[WIDTH-1]}}, A};
                hi    <= '0;
                lo    <= B;
                q     <= 1'b0;
                cnt   <= CNT_W'(N_STEPS);
                state <= RUN;
                if (state == IDLE)
                    busy <= 1'b1;
            end
        end
    end

endmodule
